// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises the system PLL from the 50 MHz reference clock. It pulses the
//   PLL reset, waits for a qualified lock, and then releases the three
//   downstream domain resets one after another. A lock timeout triggers a
//   retry. Loss of lock, or a relock request while running, starts the whole
//   sequence again.
//
//   Optional feature: define PLL_SEQ_RETRY_LIMIT_EN to enable the retry limit.
//   When the limit is reached the block stops in FAIL. With the macro
//   undefined the block retries indefinitely and fail is tied low.
//
// Ports
//   refclk     in   reference clock (only clock)
//   rst        in   asynchronous active-high reset
//   locked     in   PLL lock flag, asynchronous to refclk
//   relock_req in   single-cycle request to force a new lock sequence (RUN only)
//   pll_rst    out  PLL reset, active-high
//   dom_rst    out  domain resets, active-high: [0]=24 MHz [1]=100 MHz [2]=150 MHz
//   ready      out  all domains released, lock qualified
//   fail       out  retry budget exhausted
//   retry_cnt  out  lock timeouts since the last RUN, saturating at 15
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned STAGGER       = 64,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic [2:0] dom_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  // A single phase counter serves every timed state. It is sized for the
  // longest interval, so no count can wrap.
  localparam int unsigned M1      = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int unsigned M2      = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
  localparam int unsigned CNT_MAX = (M2 > 2 * STAGGER) ? M2 : 2 * STAGGER;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAG1    = CW'(STAGGER);
  localparam logic [CW-1:0] REL_LAST = CW'(2 * STAGGER);
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_cnt_q, retry_cnt_d;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic          pll_rst_q, pll_rst_d;
  logic [2:0]    dom_rst_q, dom_rst_d;
  logic          ready_q, ready_d;

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam bit RETRY_LIMIT_EN = 1'b1;
  logic fail_q;
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) fail_q <= 1'b0;
    else     fail_q <= (state_q == S_FAIL);
  end
  assign fail = fail_q;
`else
  localparam bit RETRY_LIMIT_EN = 1'b0;
  assign fail = 1'b0;
`endif

  assign locked_s = sync_q[1];

  // State register, counters, synchronizer and registered outputs
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      dom_rst_q   <= '1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      sync_q      <= {sync_q[0], locked};
      pll_rst_q   <= pll_rst_d;
      dom_rst_q   <= dom_rst_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    retry_cnt_d = retry_cnt_q;
    unique case (state_q)
      S_RESET_PLL: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (RETRY_LIMIT_EN && (retry_cnt_q == MAX_R)) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_RESET_PLL;
            if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + 4'd1;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s)              state_d = S_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!locked_s)              state_d = S_RESET_PLL;
        else if (cnt_q == REL_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d       = cnt_q;
        retry_cnt_d = '0;
        // Lock loss and relock request collapse into one restart
        if (!locked_s || relock_req) state_d = S_RESET_PLL;
      end
      S_FAIL:  cnt_d = cnt_q;
      default: state_d = S_RESET_PLL;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode. The outputs are registered from the current state, so they
  // trail the state by one cycle. The exception is the lock-loss and relock
  // override in RELEASE and RUN: it forces the domain resets on the same edge
  // that leaves those states.
  always_comb begin
    pll_rst_d = 1'b0;
    dom_rst_d = '1;
    ready_d   = 1'b0;
    unique case (state_q)
      S_RESET_PLL, S_FAIL: pll_rst_d = 1'b1;
      S_WAIT_LOCK, S_STABLE: ;
      S_RELEASE: begin
        if (locked_s) begin
          dom_rst_d[0] = 1'b0;
          dom_rst_d[1] = (cnt_q < STAG1);
          dom_rst_d[2] = (cnt_q < REL_LAST);
          ready_d      = (cnt_q == REL_LAST);
        end
      end
      S_RUN: begin
        if (locked_s && !relock_req) begin
          dom_rst_d = '0;
          ready_d   = 1'b1;
        end
      end
      default: pll_rst_d = 1'b1;
    endcase
  end

  assign pll_rst   = pll_rst_q;
  assign dom_rst   = dom_rst_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_cnt_q;

endmodule
